// File: rtl/counter_modulo.sv
// -----------------------------------------------------------------------------
// counter_modulo
//   Up/down modulo counter with an enable prescaler, a synchronous load and
//   selectable wrap or saturate behaviour at the count limits (0 and
//   MAX_VALUE).
//
// Parameters
//   WIDTH     : counter width in bits (2..32)
//   MAX_VALUE : terminal count (1..2**WIDTH-1)
//   PRESCALE  : enabled cycles per count step (1..65535)
//   SATURATE  : 0 = wrap at the limits, 1 = hold at the limits
//
// Ports
//   clock_i         : clock, all state updates on the rising edge
//   reset_i         : synchronous active-high reset
//   enable_i        : count enable, advances the prescaler
//   up_i            : direction, 1 = up, 0 = down
//   load_i          : synchronous load strobe
//   load_value_i    : value loaded (clamped to MAX_VALUE)
//   counter_value_o : current count, registered
//   terminal_o      : count is at the limit for the current direction
//   wrap_o          : registered one-cycle pulse after a step taken at a limit
// -----------------------------------------------------------------------------
module counter_modulo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VALUE = 255,
  parameter int unsigned PRESCALE  = 1,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] counter_value_o,
  output logic             terminal_o,
  output logic             wrap_o
);

  // A PRESCALE of 1 still gets a one-bit prescaler that never leaves 0.
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VALUE);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  prescale_q, prescale_d;
  logic             wrap_q, wrap_d;

  logic at_max;
  logic at_zero;
  logic step;

  assign at_max  = (count_q == MAX_C);
  assign at_zero = (count_q == '0);
  assign step    = enable_i && (prescale_q == PS_LAST);

  // Next-state logic. Reset is handled in the register block, so here the
  // priority is load, then step/prescale, then hold.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave it unassigned; otherwise synthesis infers a latch.
    count_d    = count_q;
    prescale_d = prescale_q;
    wrap_d     = 1'b0;

    if (load_i) begin
      // A load wins over a coincident step and clears any partial prescale.
      count_d    = (load_value_i > MAX_C) ? MAX_C : load_value_i;
      prescale_d = '0;
    end else if (enable_i) begin
      if (step) begin
        prescale_d = '0;
        if (up_i) begin
          if (at_max) begin
            count_d = SATURATE ? MAX_C : '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (at_zero) begin
            count_d = SATURATE ? '0 : MAX_C;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end else begin
        prescale_d = prescale_q + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    if (reset_i) begin
      count_q    <= '0;
      prescale_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      prescale_q <= prescale_d;
      wrap_q     <= wrap_d;
    end
  end

  assign counter_value_o = count_q;
  assign wrap_o          = wrap_q;
  // Only output with a combinational path: it follows up_i immediately.
  assign terminal_o      = up_i ? at_max : at_zero;

endmodule

// File: tb/tb_counter_modulo.sv
// -----------------------------------------------------------------------------
// tb_counter_modulo
//   Self-checking bench for counter_modulo. Three instances share one set of
//   inputs (WIDTH=4, MAX_VALUE=9):
//     dut_a : PRESCALE=1, SATURATE=0  (table-driven vectors)
//     dut_s : PRESCALE=1, SATURATE=1  (hand-written saturation sequence)
//     dut_p : PRESCALE=3, SATURATE=0  (hand-written prescale sequences)
//   Every sequence starts with a reset, so activity on the instances that are
//   not being checked is irrelevant.
// -----------------------------------------------------------------------------
module tb_counter_modulo;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       up;
  logic       load;
  logic [3:0] load_value;

  logic [3:0] cnt_a, cnt_s, cnt_p;
  logic       term_a, term_s, term_p;
  logic       wrap_a, wrap_s, wrap_p;

  int n_cmp = 0;
  int n_err = 0;

  counter_modulo #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(1'b0)) dut_a (
    .clock_i(clk), .reset_i(reset), .enable_i(enable), .up_i(up), .load_i(load),
    .load_value_i(load_value), .counter_value_o(cnt_a), .terminal_o(term_a),
    .wrap_o(wrap_a)
  );

  counter_modulo #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(1'b1)) dut_s (
    .clock_i(clk), .reset_i(reset), .enable_i(enable), .up_i(up), .load_i(load),
    .load_value_i(load_value), .counter_value_o(cnt_s), .terminal_o(term_s),
    .wrap_o(wrap_s)
  );

  counter_modulo #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(3), .SATURATE(1'b0)) dut_p (
    .clock_i(clk), .reset_i(reset), .enable_i(enable), .up_i(up), .load_i(load),
    .load_value_i(load_value), .counter_value_o(cnt_p), .terminal_o(term_p),
    .wrap_o(wrap_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic       wrap;
    logic       term;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs for one rising edge, then sample 1 time unit after it.
  task automatic drive(input logic rst, input logic en, input logic u,
                       input logic ld, input logic [3:0] lv);
    reset      = rst;
    enable     = en;
    up         = u;
    load       = ld;
    load_value = lv;
    @(posedge clk);
    #1;
  endtask

  // which: 0 = dut_a, 1 = dut_s, 2 = dut_p
  task automatic chk(input int which, input string name, input int c, input int w, input int t);
    logic [3:0] ac;
    logic       aw, at;
    case (which)
      0:       begin ac = cnt_a; aw = wrap_a; at = term_a; end
      1:       begin ac = cnt_s; aw = wrap_s; at = term_s; end
      default: begin ac = cnt_p; aw = wrap_p; at = term_p; end
    endcase
    check({name, " cnt"},  32'(ac), 32'(c));
    check({name, " wrap"}, 32'(aw), 32'(w));
    check({name, " term"}, 32'(at), 32'(t));
  endtask

  function automatic void add(input logic rst, input logic en, input logic u, input logic ld,
                              input logic [3:0] lv, input logic [3:0] c, input logic w,
                              input logic t);
    vec_t v;
    v.rst = rst; v.en = en; v.up = u; v.ld = ld; v.lv = lv;
    v.cnt = c; v.wrap = w; v.term = t;
    vecs.push_back(v);
  endfunction

  initial begin : main
    int en_pat[7];
    int cnt_pat[7];

    reset = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0; load_value = '0;

    // ---------------- dut_a vector table ----------------
    //  rst en up ld lv   cnt wrap term
    // Up count from reset: 0..9, 0, 1 with one wrap pulse after 9->0.
    add(1, 0, 1, 0, 0,    0, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 1, 1, 0, 0, 4'(k), 0, (k == 9));
    add(0, 1, 1, 0, 0,    0, 1, 0);
    add(0, 1, 1, 0, 0,    1, 0, 0);
    // Down count from reset: 0, 9, 8, 7 with wrap after 0->9; then hold.
    add(1, 0, 0, 0, 0,    0, 0, 1);
    add(0, 1, 0, 0, 0,    9, 1, 0);
    add(0, 1, 0, 0, 0,    8, 0, 0);
    add(0, 1, 0, 0, 0,    7, 0, 0);
    add(0, 0, 0, 0, 0,    7, 0, 0);
    // Load 15 clamps to 9 and beats a coincident step, even one at the limit.
    add(0, 1, 1, 1, 15,   9, 0, 1);
    add(0, 1, 1, 1, 15,   9, 0, 1);
    add(0, 1, 1, 0, 0,    0, 1, 0);
    add(0, 0, 1, 1, 5,    5, 0, 0);
    add(0, 1, 0, 0, 0,    4, 0, 0);
    // Reset overrides load and enable.
    add(1, 1, 1, 1, 5,    0, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].lv);
      chk(0, $sformatf("vec%0d", i), vecs[i].cnt, vecs[i].wrap, vecs[i].term);
    end

    // ---------------- dut_s saturation ----------------
    drive(1, 0, 1, 0, 0);
    chk(1, "sat_rst", 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      drive(0, 1, 1, 0, 0);
      chk(1, $sformatf("sat_up%0d", k), k, 0, (k == 9));
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0);
      chk(1, $sformatf("sat_hold%0d", k), 9, 1, 1);
    end
    drive(0, 0, 1, 0, 0);
    chk(1, "sat_idle", 9, 0, 1);
    drive(0, 1, 0, 0, 0);
    chk(1, "sat_down", 8, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk(1, "sat_rst_dn", 0, 0, 1);
    drive(0, 1, 0, 0, 0);
    chk(1, "sat_zero0", 0, 1, 1);
    drive(0, 1, 0, 0, 0);
    chk(1, "sat_zero1", 0, 1, 1);

    // ---------------- dut_p prescale = 3 ----------------
    drive(1, 0, 1, 0, 0);
    chk(2, "ps_rst", 0, 0, 0);
    en_pat  = '{1, 0, 1, 1, 1, 1, 1};
    cnt_pat = '{0, 0, 0, 1, 1, 1, 2};
    for (int k = 0; k < 7; k++) begin
      drive(0, 1'(en_pat[k]), 1, 0, 0);
      chk(2, $sformatf("ps_en%0d", k), cnt_pat[k], 0, 0);
    end
    // Prescaler now 0. Advance it to 2, then reset together with load.
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    chk(2, "ps_mid", 2, 0, 0);
    drive(1, 1, 1, 1, 5);
    chk(2, "ps_rst_ld", 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    chk(2, "ps_after_rst0", 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    chk(2, "ps_after_rst1", 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    chk(2, "ps_after_rst2", 1, 0, 0);
    // Prescaler at 1: load must clear it, so three more enables are needed.
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 15);
    chk(2, "ps_load", 9, 0, 1);
    drive(0, 1, 1, 0, 0);
    chk(2, "ps_after_ld0", 9, 0, 1);
    drive(0, 1, 1, 0, 0);
    chk(2, "ps_after_ld1", 9, 0, 1);
    drive(0, 1, 1, 0, 0);
    chk(2, "ps_after_ld2", 0, 1, 0);
    // Direction toggles between steps; only up_i at the step edge matters.
    drive(0, 1, 0, 0, 0);
    chk(2, "ps_dir0", 0, 0, 1);
    drive(0, 1, 1, 0, 0);
    chk(2, "ps_dir1", 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk(2, "ps_dir2", 9, 1, 0);
    // terminal_o follows up_i combinationally with no clock edge.
    up = 1'b1;
    #1;
    check("ps_term_up", 32'(term_p), 32'd1);
    up = 1'b0;
    #1;
    check("ps_term_dn", 32'(term_p), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
